// File: rtl/delay_pkg.sv
// Shared types and constants for the variable delay line.
package delay_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int MAX_DELAY = DEPTH - 1;

    typedef logic [DATA_W-1:0] sample_t;

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port sample buffer: one synchronous write port, one synchronous read port.
module delay_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/variable_delay_line.sv
// Streaming delay line with run-time programmable delay, one sample per clock.
module variable_delay_line
    import delay_pkg::*;
#(
    parameter int DATA_W = delay_pkg::DATA_W,
    parameter int ADDR_W = delay_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] input_sig,
    input  logic [15:0]       delay,
    output logic [DATA_W-1:0] output_sig
);

    localparam int DEPTH_L = 2 ** ADDR_W;
    localparam logic [15:0] MAX16 = 16'(DEPTH_L - 1);
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH_L);

    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] de;
    logic [ADDR_W-1:0] raddr;
    logic [ADDR_W:0]   fill;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] hold;
    logic              byp;
    logic              zero;

    always_comb begin
        de = (delay > MAX16) ? MAX16[ADDR_W-1:0] : delay[ADDR_W-1:0];
        raddr = wp - de;
    end

    // The read is issued on the same edge as the write; with De >= 1 the
    // addresses always differ, and De = 0 is served from the hold register.
    delay_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (1'b1),
        .waddr(wp),
        .wdata(input_sig),
        .raddr(raddr),
        .rdata(rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp   <= '0;
            fill <= '0;
            byp  <= 1'b0;
            zero <= 1'b1;
            hold <= '0;
        end else begin
            wp   <= wp + 1'b1;
            fill <= (fill == FULL) ? fill : fill + 1'b1;
            byp  <= (de == '0);
            // fill is the count of samples written before this edge
            zero <= ({1'b0, de} > fill);
            hold <= input_sig;
        end
    end

    always_comb begin
        output_sig = rdata;
        if (zero) begin
            output_sig = '0;
        end else if (byp) begin
            output_sig = hold;
        end
    end

endmodule

// File: tb/tb_variable_delay_line.sv
// Randomised self-checking bench for variable_delay_line against a sample-history model.
module tb_variable_delay_line;

    logic        clk;
    logic        rst_n;
    logic [15:0] input_sig;
    logic [15:0] delay;
    logic [15:0] output_sig;

    int total = 0;
    int bad = 0;
    logic [15:0] hist [$];

    variable_delay_line dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .input_sig (input_sig),
        .delay     (delay),
        .output_sig(output_sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Output after edge n is the input of edge n-De, or 0 if that predates reset.
    task automatic step(input string tag, input logic [15:0] din,
                        input logic [15:0] d, input logic rst);
        int de;
        int idx;
        logic [15:0] exp;
        @(negedge clk);
        input_sig = din;
        delay = d;
        rst_n = ~rst;
        @(posedge clk);
        if (rst) begin
            hist.delete();
            exp = '0;
        end else begin
            hist.push_back(din);
            de = (int'(d) > 255) ? 255 : int'(d);
            idx = hist.size() - 1;
            exp = (de <= idx) ? hist[idx-de] : 16'h0;
        end
        #1 chk(tag, output_sig, exp);
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) step("reset", 16'(i + 7), 16'd5, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        input_sig = '0;
        delay = '0;

        do_reset(3);
        for (int n = 0; n < 40; n++) step("ramp_d5", 16'(n), 16'd5, 1'b0);

        do_reset(2);
        for (int n = 0; n < 8; n++) step("pre_d0", 16'(n), 16'd3, 1'b0);
        step("d0_a", 16'h1234, 16'd0, 1'b0);
        chk("d0_a_const", output_sig, 16'h1234);
        step("d0_b", 16'hABCD, 16'd0, 1'b0);
        chk("d0_b_const", output_sig, 16'hABCD);

        do_reset(2);
        for (int n = 0; n < 600; n++) step("clamp300", 16'(n), 16'd300, 1'b0);

        do_reset(2);
        for (int n = 0; n < 1000; n++) step("wrap_d10", 16'(n), 16'd10, 1'b0);
        chk("wrap_last", output_sig, 16'd989);

        do_reset(2);
        for (int n = 0; n <= 100; n++) step("pre_rst", 16'(n), 16'd5, 1'b0);
        do_reset(3);
        for (int n = 0; n < 30; n++) step("post_rst", 16'(500 + n), 16'd5, 1'b0);

        do_reset(2);
        for (int n = 0; n < 70; n++) begin
            logic [15:0] d;
            d = (n < 50) ? 16'd5 : (n < 55) ? 16'd2 : 16'd8;
            step("dchg", 16'(n), d, 1'b0);
            if (n == 50) chk("dchg_e50", output_sig, 16'd48);
            if (n == 51) chk("dchg_e51", output_sig, 16'd49);
            if (n == 60) chk("dchg_e60", output_sig, 16'd52);
        end

        do_reset(2);
        begin
            logic [15:0] d;
            d = 16'd4;
            for (int n = 0; n < 2000; n++) begin
                if ($urandom_range(0, 29) == 0) begin
                    case ($urandom_range(0, 3))
                        0: d = 16'd0;
                        1: d = 16'($urandom);
                        default: d = 16'($urandom_range(0, 300));
                    endcase
                end
                step("rand", 16'($urandom), d,
                     ($urandom_range(0, 399) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
